// File: rtl/rf_envelope_ma.sv
// Four-channel envelope detector: rectifies reader samples and smooths each
// channel with a boxcar moving average, one frame per start.
module rf_envelope_ma #(
    parameter int LOG2_WIN  = 3,
    parameter int FRAME_LEN = 24100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] rf_in1,
    input  logic [15:0] rf_in2,
    input  logic [15:0] rf_in3,
    input  logic [15:0] rf_in4,
    output logic        inc_count,
    output logic [15:0] env1,
    output logic [15:0] env2,
    output logic [15:0] env3,
    output logic [15:0] env4,
    output logic        env_valid,
    input  logic        env_ready,
    output logic [15:0] env_idx,
    output logic        env_last,
    output logic        busy,
    output logic        done
);

    localparam int N  = 1 << LOG2_WIN;
    localparam int SW = 16 + LOG2_WIN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPT,
        S_ACC,
        S_OUT,
        S_REQ,
        S_WAIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [15:0]         w_rf       [4];
    logic [15:0]         r_abs      [4];
    logic [15:0]         r_hist     [4][N];
    logic [SW-1:0]       r_sum      [4];
    logic [SW-1:0]       w_sum_next [4];
    logic [15:0]         r_env      [4];
    logic [LOG2_WIN-1:0] r_wp;
    logic [15:0]         r_idx;
    logic                r_done;
    logic                w_last;
    logic                w_hs;

    // Two's-complement magnitude; -32768 maps to 0x8000 read as unsigned.
    function automatic logic [15:0] f_abs(input logic [15:0] x);
        return x[15] ? 16'(~x + 16'd1) : x;
    endfunction

    assign w_rf[0] = rf_in1;
    assign w_rf[1] = rf_in2;
    assign w_rf[2] = rf_in3;
    assign w_rf[3] = rf_in4;

    assign w_last = (r_idx == 16'(FRAME_LEN - 1));
    assign w_hs   = (r_state == S_OUT) && env_ready;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_sum_next[c] = r_sum[c] + SW'(r_abs[c]) - SW'(r_hist[c][r_wp]);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_CAPT;
            S_CAPT:  w_next = S_ACC;
            S_ACC:   w_next = S_OUT;
            S_OUT:   if (env_ready) w_next = w_last ? S_IDLE : S_REQ;
            S_REQ:   w_next = S_WAIT;
            S_WAIT:  w_next = S_CAPT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 4; c++) begin
                r_abs[c] <= '0;
                r_sum[c] <= '0;
                r_env[c] <= '0;
                for (int k = 0; k < N; k++) r_hist[c][k] <= '0;
            end
            r_wp   <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_hs && w_last;
            if (r_state == S_IDLE && start) begin
                for (int c = 0; c < 4; c++) begin
                    r_sum[c] <= '0;
                    r_env[c] <= '0;
                    for (int k = 0; k < N; k++) r_hist[c][k] <= '0;
                end
                r_wp  <= '0;
                r_idx <= '0;
            end
            if (r_state == S_CAPT) begin
                for (int c = 0; c < 4; c++) r_abs[c] <= f_abs(w_rf[c]);
            end
            if (r_state == S_ACC) begin
                for (int c = 0; c < 4; c++) begin
                    r_sum[c]        <= w_sum_next[c];
                    r_hist[c][r_wp] <= r_abs[c];
                    r_env[c]        <= 16'(w_sum_next[c] >> LOG2_WIN);
                end
                r_wp <= r_wp + 1'b1;
            end
            if (w_hs && !w_last) begin
                r_idx <= r_idx + 16'd1;
            end
        end
    end

    assign env1      = r_env[0];
    assign env2      = r_env[1];
    assign env3      = r_env[2];
    assign env4      = r_env[3];
    assign env_idx   = r_idx;
    assign env_valid = (r_state == S_OUT);
    assign env_last  = env_valid && w_last;
    assign busy      = (r_state != S_IDLE);
    assign inc_count = (r_state == S_REQ);
    assign done      = r_done;

endmodule

// File: tb/tb_rf_envelope_ma.sv
// Directed bench for rf_envelope_ma: ramp-up, stall, frame end, abort
// and ignored start, with hand-computed envelope values.
module tb_rf_envelope_ma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] rf_in1, rf_in2, rf_in3, rf_in4;
    logic        inc_count;
    logic [15:0] env1, env2, env3, env4;
    logic        env_valid;
    logic        env_ready;
    logic [15:0] env_idx;
    logic        env_last;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;
    int inc_cnt = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;

    int tbl1 [8] = '{12, 25, 37, 50, 62, 75, 87, 100};

    always #5 clk = ~clk;

    rf_envelope_ma #(.LOG2_WIN(3), .FRAME_LEN(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rf_in1(rf_in1), .rf_in2(rf_in2), .rf_in3(rf_in3), .rf_in4(rf_in4),
        .inc_count(inc_count),
        .env1(env1), .env2(env2), .env3(env3), .env4(env4),
        .env_valid(env_valid), .env_ready(env_ready),
        .env_idx(env_idx), .env_last(env_last),
        .busy(busy), .done(done)
    );

    always @(posedge clk) begin
        if (inc_count) inc_cnt <= inc_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (done && env_valid) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output bit ok);
        for (int i = 0; i < 20; i++) begin
            if (env_valid) break;
            @(negedge clk);
        end
        ok = env_valid;
        if (!ok) chk("valid_timeout", 0, 1);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("lat_e0", env_valid, 0);
        @(negedge clk);
        chk("lat_e1", env_valid, 0);
        @(negedge clk);
        chk("lat_e2", env_valid, 1);
    endtask

    task automatic run_frame(input int hold_k, input int pulse_k,
                             input int abort_k);
        bit ok;
        int inc0, done0, n;
        logic [15:0] s_e1, s_idx;
        inc0  = inc_cnt;
        done0 = done_cnt;
        for (int k = 0; k < 16; k++) begin
            wait_valid(ok);
            if (!ok) return;
            n = (k + 1 < 8) ? k + 1 : 8;
            chk("idx", env_idx, k);
            chk("env1", env1, tbl1[n-1]);
            chk("env2", env2, 4096 * n);
            chk("env3", env3, n);
            chk("env4", env4, 0);
            chk("last", env_last, (k == 15) ? 1 : 0);
            if (k == hold_k) begin
                env_ready = 1'b0;
                s_e1  = env1;
                s_idx = env_idx;
                repeat (10) begin
                    @(negedge clk);
                    chk("hold_valid", env_valid, 1);
                    chk("hold_env1", env1, s_e1);
                    chk("hold_idx", env_idx, s_idx);
                end
                chk("hold_inc", inc_cnt, inc0 + k);
                env_ready = 1'b1;
            end
            if (k == pulse_k) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (k == 15) begin
                chk("done_pulse", done, 1);
                chk("done_novalid", env_valid, 0);
                @(negedge clk);
                chk("done_one_cycle", done, 0);
            end
            if (k == abort_k - 1) begin
                repeat (3) @(posedge clk);
                #2 chk("busy_pre_abort", busy, 1);
                reset = 1'b0;
                #1;
                chk("abort_valid", env_valid, 0);
                chk("abort_env1", env1, 0);
                chk("abort_env2", env2, 0);
                chk("abort_idx", env_idx, 0);
                chk("abort_busy", busy, 0);
                chk("abort_inc", inc_count, 0);
                chk("abort_done", done, 0);
                @(negedge clk);
                reset = 1'b1;
                repeat (3) @(negedge clk);
                chk("abort_no_done", done_cnt, done0);
                return;
            end
        end
        repeat (3) @(negedge clk);
        chk("inc_strobes", inc_cnt - inc0, 15);
        chk("done_count", done_cnt - done0, 1);
        chk("done_valid_overlap", overlap_cnt, 0);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        env_ready = 1'b1;
        rf_in1    = 16'd100;
        rf_in2    = 16'h8000;
        rf_in3    = 16'hFFF8;
        rf_in4    = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_valid", env_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inc", inc_count, 0);
        chk("rst_done", done, 0);
        chk("rst_env1", env1, 0);
        chk("rst_idx", env_idx, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        do_start();
        run_frame(3, -1, -1);

        do_start();
        run_frame(-1, 5, -1);

        do_start();
        run_frame(-1, -1, 7);

        do_start();
        run_frame(-1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
